// File: rtl/multiword_add_sequencer_pkg.sv
// Shared types and sizing helpers for the chunked multi-word adder sequencer.
package multiword_add_sequencer_pkg;

   // state | meaning
   // IDLE  | waiting for Start
   // RUN   | one chunk add per cycle, k = 0 .. NCHUNK-1
   // DONE  | Done pulse; Sum/Co final; Start accepted back-to-back
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic int nchunk(input int width, input int chunk);
      return width / chunk;
   endfunction

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/multiword_add_sequencer_counter.sv
// Up-counter on the rising clock edge with synchronous reset and clear.
module UPCOUNTER_POSEDGE #(
   parameter int SIZE = 2
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            clear,
   input  logic            enable,
   output logic [SIZE-1:0] count
);

   always_ff @(posedge clock) begin
      if (reset || clear) count <= '0;
      else if (enable)    count <= count + SIZE'(1);
   end

endmodule

// File: rtl/multiword_add_sequencer_full_adder.sv
// SIZE-bit ripple adder slice; carry out returned on co[0].
module FULL_ADDER #(
   parameter int SIZE = 8
) (
   input  logic [SIZE-1:0] a,
   input  logic [SIZE-1:0] b,
   input  logic            ci,
   output logic [SIZE-1:0] s,
   output logic [0:0]      co
);

   assign {co, s} = {1'b0, a} + {1'b0, b} + {{SIZE{1'b0}}, ci};

endmodule

// File: rtl/multiword_add_sequencer.sv
// WIDTH-bit add built from one CHUNK-bit adder stepped over NCHUNK cycles.
// Optional subtract mode is enabled by defining SUBTRACT_EN.
module multiword_add_sequencer
   import multiword_add_sequencer_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             Start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Ci,
`ifdef SUBTRACT_EN
   input  logic             Sub,
`endif
   output logic             Busy,
   output logic             Done,
   output logic [WIDTH-1:0] Sum,
   output logic             Co
);

   localparam int NCHUNK = nchunk(WIDTH, CHUNK);
   localparam int IDXW   = idx_width(NCHUNK);
   localparam logic [IDXW-1:0] K_LAST = IDXW'(NCHUNK - 1);

   state_t            state, state_next;
   logic              load, step;
   logic [IDXW-1:0]   k;
   logic [WIDTH-1:0]  a_reg, b_reg;
   logic              carry;
   logic [CHUNK-1:0]  fa_s;
   logic [0:0]        fa_co;
   logic              sub_sel;

`ifdef SUBTRACT_EN
   assign sub_sel = Sub;
`else
   assign sub_sel = 1'b0;
`endif

   always_ff @(posedge Clock) begin
      if (Reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      load       = 1'b0;
      step       = 1'b0;
      case (state)
         IDLE: begin
            if (Start) begin
               load       = 1'b1;
               state_next = RUN;
            end
         end
         RUN: begin
            step = 1'b1;
            if (k == K_LAST) state_next = DONE;
         end
         DONE: begin
            if (Start) begin
               load       = 1'b1;
               state_next = RUN;
            end else begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign Busy = (state == RUN);
   assign Done = (state == DONE);

   UPCOUNTER_POSEDGE #(.SIZE(IDXW)) u_chunk_idx (
      .clock  (Clock),
      .reset  (Reset),
      .clear  (load),
      .enable (step),
      .count  (k)
   );

   FULL_ADDER #(.SIZE(CHUNK)) u_adder (
      .a  (a_reg[k*CHUNK +: CHUNK]),
      .b  (b_reg[k*CHUNK +: CHUNK]),
      .ci (carry),
      .s  (fa_s),
      .co (fa_co)
   );

   // Subtract is A + ~B + 1: invert B at load and seed the carry with 1.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         a_reg <= '0;
         b_reg <= '0;
         carry <= 1'b0;
         Sum   <= '0;
         Co    <= 1'b0;
      end else if (load) begin
         a_reg <= A;
         b_reg <= sub_sel ? ~B : B;
         carry <= sub_sel ? 1'b1 : Ci;
      end else if (step) begin
         Sum[k*CHUNK +: CHUNK] <= fa_s;
         carry                 <= fa_co[0];
         if (k == K_LAST) Co <= fa_co[0];
      end
   end

endmodule
